mem_wb_register: RTL and testbench
==================================

# mem_wb_register

Pipeline register between the MEM and WB stages of the 5-stage RV32I core. It captures every MEM-stage quantity the write-back stage needs on each rising clock edge and presents it as registered WB-stage outputs one cycle later. It supports an asynchronous active-low reset and a synchronous flush that inserts a bubble (all-zero NOP).

## Interface
- XLEN, 32, datapath width.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous bubble insert, active-high.
- stall  input  1  hold request, active-high; present only with MEM_WB_STALL_EN.
- MEM_pc_plus_4  input  XLEN  PC+4 of the instruction in MEM.
- MEM_register_file_write_data_select  input  3  WB write-data mux select.
- MEM_imm  input  XLEN  immediate.
- MEM_csr_read_data  input  XLEN  CSR read value.
- MEM_alu_result  input  XLEN  ALU result.
- MEM_register_write_enable  input  1  register-file write enable.
- MEM_csr_write_enable  input  1  CSR write enable.
- MEM_rd  input  5  destination register index.
- MEM_byte_enable_logic_register_file_write_data  input  XLEN  load data after byte-enable alignment and extension.
- WB_* outputs: one registered output per MEM_* input, with identical names (WB_ prefix replacing MEM_) and widths.

## Operation
- Priority per clock edge: reset (async) > flush > stall (if compiled in) > load.
- Reset low: all WB_* outputs are 0 immediately, independent of clk, and stay 0 while reset is low.
- flush high at a rising edge: all WB_* outputs become 0. This gives write enables 0, rd 0, and select 3'b000, which is a NOP.
- stall high (flush low): all WB_* outputs hold their values.
- Otherwise every WB_* output takes its MEM_* input.
- No arithmetic, no decoding. Fields pass bit-exact with no width conversion.
- Flush zeroes data fields as well as control fields, so a flushed stage is exactly all-zero.

## Timing
- Latency is 1 cycle. Inputs sampled at a rising edge appear on outputs immediately after that edge.
- Input changes between edges have no effect on outputs.
- If inputs stay constant over consecutive edges, outputs stay unchanged.
- Reset release is synchronous to nothing. The first edge with reset high loads normally, or flushes if flush is high.
- If reset is asserted mid-operation, outputs clear asynchronously and the pending capture is lost.
- flush and stall both high: flush wins and outputs become 0.
- Flush lasts exactly as many cycles as it is held. The edge after deassertion loads the MEM inputs.

## Configuration
- MEM_WB_STALL_EN
  - Defined: adds the `stall` port and the hold behaviour.
  - Undefined: the port is absent and the register loads every non-flush, non-reset edge.

## Structure
- Shared package `pipeline_pkg`:
  - XLEN default.
  - Write-data select encodings: 3'b000 NOP/none, 3'b001 load data (byte-enable logic), 3'b010 ALU result, 3'b011 CSR read data, 3'b100 PC+4, 3'b101 immediate.
  - NOP constant of all zeros.
- Natural sub-module: `pipe_reg`, a parameterised-width flop with async active-low reset, sync flush-to-zero and optional hold. Instantiate it once per field, or once on a concatenated bus.

## Test plan
- Reset: hold reset low for 30 ns with arbitrary inputs, then release -> every WB_* output is 0 during reset and remains 0 until the first loaded edge.
- Load ALU op: pc_plus_4=0x4, select=3'b010, alu_result=0xB, reg_we=1, csr_we=0, rd=6, BE data=0xA, imm=csr=0 -> identical values on WB_* one edge later; no change before that edge.
- Hold-constant and load: keep the same inputs for another edge -> outputs unchanged. Then drive pc_plus_4=0x8, select=3'b001, imm=0x20, alu=0x10000020, rd=7, BE data=0xDEADBEEF -> outputs unchanged until the next rising edge, then match.
- Flush: assert flush across one rising edge -> all WB_* outputs are 0, including pc_plus_4 and BE data.
- CSR op after flush: pc_plus_4=0xC, select=3'b011, csr_read_data=0xCAFEBABE, reg_we=1, csr_we=1, rd=5'b10001, BE data=0xCAFEBABE -> outputs stay 0 until the next edge, then match.
- Priority (MEM_WB_STALL_EN): stall=1 holds values; stall=1 with flush=1 gives 0; reset pulled low mid-cycle clears outputs asynchronously.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, WB write-data select codes and
// the packed MEM/WB payload that travels between the two stages.
package pipeline_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    WD_NONE = 3'b000,
    WD_LOAD = 3'b001,
    WD_ALU  = 3'b010,
    WD_CSR  = 3'b011,
    WD_PC4  = 3'b100,
    WD_IMM  = 3'b101
  } wd_sel_e;

  // Field order is fixed; the register stage treats it as one opaque bus.
  typedef struct packed {
    logic [XLEN-1:0] pc_plus_4;
    logic [2:0]      wd_sel;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] csr_read_data;
    logic [XLEN-1:0] alu_result;
    logic            reg_we;
    logic            csr_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] be_data;
  } mem_wb_t;

  localparam int      MEM_WB_W = $bits(mem_wb_t);
  localparam mem_wb_t MEM_WB_NOP = '0;

endpackage

// File: rtl/mem_wb_register_if.sv
// MEM->WB stage bundle. The stall signal exists only when MEM_WB_STALL_EN is
// defined.
interface mem_wb_register_if;
  import pipeline_pkg::*;

  logic            flush;
`ifdef MEM_WB_STALL_EN
  logic            stall;
`endif
  logic [XLEN-1:0] MEM_pc_plus_4;
  logic [2:0]      MEM_register_file_write_data_select;
  logic [XLEN-1:0] MEM_imm;
  logic [XLEN-1:0] MEM_csr_read_data;
  logic [XLEN-1:0] MEM_alu_result;
  logic            MEM_register_write_enable;
  logic            MEM_csr_write_enable;
  logic [4:0]      MEM_rd;
  logic [XLEN-1:0] MEM_byte_enable_logic_register_file_write_data;

  logic [XLEN-1:0] WB_pc_plus_4;
  logic [2:0]      WB_register_file_write_data_select;
  logic [XLEN-1:0] WB_imm;
  logic [XLEN-1:0] WB_csr_read_data;
  logic [XLEN-1:0] WB_alu_result;
  logic            WB_register_write_enable;
  logic            WB_csr_write_enable;
  logic [4:0]      WB_rd;
  logic [XLEN-1:0] WB_byte_enable_logic_register_file_write_data;

  modport master (
    output flush,
`ifdef MEM_WB_STALL_EN
    output stall,
`endif
    output MEM_pc_plus_4, MEM_register_file_write_data_select, MEM_imm,
           MEM_csr_read_data, MEM_alu_result, MEM_register_write_enable,
           MEM_csr_write_enable, MEM_rd,
           MEM_byte_enable_logic_register_file_write_data,
    input  WB_pc_plus_4, WB_register_file_write_data_select, WB_imm,
           WB_csr_read_data, WB_alu_result, WB_register_write_enable,
           WB_csr_write_enable, WB_rd,
           WB_byte_enable_logic_register_file_write_data
  );

  modport slave (
    input  flush,
`ifdef MEM_WB_STALL_EN
    input  stall,
`endif
    input  MEM_pc_plus_4, MEM_register_file_write_data_select, MEM_imm,
           MEM_csr_read_data, MEM_alu_result, MEM_register_write_enable,
           MEM_csr_write_enable, MEM_rd,
           MEM_byte_enable_logic_register_file_write_data,
    output WB_pc_plus_4, WB_register_file_write_data_select, WB_imm,
           WB_csr_read_data, WB_alu_result, WB_register_write_enable,
           WB_csr_write_enable, WB_rd,
           WB_byte_enable_logic_register_file_write_data
  );

endinterface

// File: rtl/mem_wb_register_pipe_reg.sv
// Generic pipeline flop: async active-low clear, sync flush-to-zero, then hold,
// then load.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_hold,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_q <= '0;
    else if (i_flush) r_q <= '0;
    else if (!i_hold) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register of the RV32I core. All fields share one flop bus;
// flush yields an all-zero NOP. Define MEM_WB_STALL_EN to add stall/hold.
module mem_wb_register
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mem_wb_register_if.slave   bus
);

  mem_wb_t w_mem;
  mem_wb_t w_wb;
  logic    w_hold;

  always_comb begin
    w_mem               = MEM_WB_NOP;
    w_mem.pc_plus_4     = bus.MEM_pc_plus_4;
    w_mem.wd_sel        = bus.MEM_register_file_write_data_select;
    w_mem.imm           = bus.MEM_imm;
    w_mem.csr_read_data = bus.MEM_csr_read_data;
    w_mem.alu_result    = bus.MEM_alu_result;
    w_mem.reg_we        = bus.MEM_register_write_enable;
    w_mem.csr_we        = bus.MEM_csr_write_enable;
    w_mem.rd            = bus.MEM_rd;
    w_mem.be_data       = bus.MEM_byte_enable_logic_register_file_write_data;
  end

`ifdef MEM_WB_STALL_EN
  assign w_hold = bus.stall;
`else
  assign w_hold = 1'b0;
`endif

  pipe_reg #(.W(MEM_WB_W)) u_reg (
    .clk     (clk),
    .reset   (reset),
    .i_flush (bus.flush),
    .i_hold  (w_hold),
    .i_d     (w_mem),
    .o_q     (w_wb)
  );

  assign bus.WB_pc_plus_4                                  = w_wb.pc_plus_4;
  assign bus.WB_register_file_write_data_select            = w_wb.wd_sel;
  assign bus.WB_imm                                        = w_wb.imm;
  assign bus.WB_csr_read_data                              = w_wb.csr_read_data;
  assign bus.WB_alu_result                                 = w_wb.alu_result;
  assign bus.WB_register_write_enable                      = w_wb.reg_we;
  assign bus.WB_csr_write_enable                           = w_wb.csr_we;
  assign bus.WB_rd                                         = w_wb.rd;
  assign bus.WB_byte_enable_logic_register_file_write_data = w_wb.be_data;

endmodule

// File: tb/tb_mem_wb_register.sv
// Directed bench for mem_wb_register: reset, load, hold-constant, flush, async
// reset mid-cycle and, with MEM_WB_STALL_EN, stall priority.
module tb_mem_wb_register;
  import pipeline_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mem_wb_register_if bus ();

  mem_wb_register dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mem_wb_t mk(logic [31:0] pc4, logic [2:0] sel, logic [31:0] imm,
                                 logic [31:0] csr, logic [31:0] alu, logic rwe,
                                 logic cwe, logic [4:0] rd, logic [31:0] be);
    mem_wb_t v;
    v.pc_plus_4 = pc4; v.wd_sel = sel; v.imm = imm; v.csr_read_data = csr;
    v.alu_result = alu; v.reg_we = rwe; v.csr_we = cwe; v.rd = rd; v.be_data = be;
    return v;
  endfunction

  task automatic set_in(input mem_wb_t v);
    bus.MEM_pc_plus_4                                  = v.pc_plus_4;
    bus.MEM_register_file_write_data_select            = v.wd_sel;
    bus.MEM_imm                                        = v.imm;
    bus.MEM_csr_read_data                              = v.csr_read_data;
    bus.MEM_alu_result                                 = v.alu_result;
    bus.MEM_register_write_enable                      = v.reg_we;
    bus.MEM_csr_write_enable                           = v.csr_we;
    bus.MEM_rd                                         = v.rd;
    bus.MEM_byte_enable_logic_register_file_write_data = v.be_data;
  endtask

  function automatic mem_wb_t get_out();
    return mk(bus.WB_pc_plus_4, bus.WB_register_file_write_data_select, bus.WB_imm,
              bus.WB_csr_read_data, bus.WB_alu_result, bus.WB_register_write_enable,
              bus.WB_csr_write_enable, bus.WB_rd,
              bus.WB_byte_enable_logic_register_file_write_data);
  endfunction

  task automatic chk(input string tag, input mem_wb_t obs, input mem_wb_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic edge_chk(input string tag, input mem_wb_t exp);
    @(posedge clk); #1;
    chk(tag, get_out(), exp);
  endtask

  mem_wb_t junk, v_alu, v_ld, v_csr, v_imm, v_pc4, zero;

  initial begin
    n_cmp = 0; n_bad = 0;
    zero  = '0;
    junk  = mk(32'hFFFF_FFFF, 3'b111, 32'h1234_5678, 32'h8765_4321, 32'hA5A5_A5A5,
               1'b1, 1'b1, 5'd31, 32'h5A5A_5A5A);
    v_alu = mk(32'h4, 3'b010, 32'h0, 32'h0, 32'hB, 1'b1, 1'b0, 5'd6, 32'hA);
    v_ld  = mk(32'h8, 3'b001, 32'h20, 32'h0, 32'h1000_0020, 1'b1, 1'b0, 5'd7, 32'hDEAD_BEEF);
    v_csr = mk(32'hC, 3'b011, 32'h0, 32'hCAFE_BABE, 32'h0, 1'b1, 1'b1, 5'b10001, 32'hCAFE_BABE);
    v_imm = mk(32'h10, 3'b101, 32'hFFFF_F800, 32'h0, 32'h0, 1'b1, 1'b0, 5'd1, 32'h0);
    v_pc4 = mk(32'hFFFF_FFFC, 3'b100, 32'h0, 32'h1, 32'h2, 1'b1, 1'b0, 5'd31, 32'h8000_0001);

    // Reset held 30 ns with busy inputs
    reset = 1'b0;
    bus.flush = 1'b0;
`ifdef MEM_WB_STALL_EN
    bus.stall = 1'b0;
`endif
    set_in(junk);
    #3 chk("rst_async", get_out(), zero);
    edge_chk("rst_e1", zero);
    edge_chk("rst_e2", zero);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    set_in(v_alu);
    #1 chk("rst_rel", get_out(), zero);

    edge_chk("load_alu", v_alu);
    edge_chk("hold_const", v_alu);

    @(negedge clk); set_in(v_ld);
    #1 chk("pre_ld", get_out(), v_alu);
    edge_chk("load_ld", v_ld);

    @(negedge clk); bus.flush = 1'b1;
    edge_chk("flush1", zero);

    @(negedge clk); bus.flush = 1'b0; set_in(v_csr);
    #1 chk("pre_csr", get_out(), zero);
    edge_chk("load_csr", v_csr);

    // Two-cycle flush: zero exactly while held, load on the next edge
    @(negedge clk); bus.flush = 1'b1; set_in(v_imm);
    edge_chk("flush2a", zero);
    edge_chk("flush2b", zero);
    @(negedge clk); bus.flush = 1'b0;
    edge_chk("after_flush", v_imm);

    // Mid-cycle input glitch must not reach the outputs
    @(negedge clk); set_in(junk);
    #2 set_in(v_pc4);
    #1 chk("glitch", get_out(), v_imm);
    edge_chk("load_pc4", v_pc4);

    // Async reset between edges drops the pending capture
    @(negedge clk); set_in(v_alu);
    #2 reset = 1'b0;
    #1 chk("mid_rst", get_out(), zero);
    edge_chk("rst_hold", zero);
    @(negedge clk); reset = 1'b1; bus.flush = 1'b1;
    edge_chk("rel_flush", zero);
    @(negedge clk); bus.flush = 1'b0;
    edge_chk("rel_load", v_alu);

`ifdef MEM_WB_STALL_EN
    @(negedge clk); bus.stall = 1'b1; set_in(v_csr);
    edge_chk("stall_hold", v_alu);
    edge_chk("stall_hold2", v_alu);
    @(negedge clk); bus.flush = 1'b1;
    edge_chk("stall_flush", zero);
    @(negedge clk); bus.flush = 1'b0;
    edge_chk("stall_zero", zero);
    @(negedge clk); bus.stall = 1'b0;
    edge_chk("unstall", v_csr);
    @(negedge clk); bus.stall = 1'b1;
    #2 reset = 1'b0;
    #1 chk("stall_rst", get_out(), zero);
    @(negedge clk); reset = 1'b1; bus.stall = 1'b0;
    edge_chk("stall_rel", v_csr);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
